pwm_deadtime_gen: RTL

Consumes the triangle carrier from the triangle-wave generator and produces a complementary high-side/low-side gate pair. It compares the carrier against a double-buffered duty command and inserts programmable dead time between the two outputs. It also carries a latched fault shutdown. The block sits directly downstream of the carrier generator, one instance per interleaved phase, and drives the gate-driver pins.

---
 rtl/pwm_deadtime_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM gate pair with dead-time insertion, valley-aligned
// double-buffered duty command and a latched fault shutdown.
module pwm_deadtime_gen #(
  parameter int BIT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                 MClk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic [BIT_WIDTH-1:0] TWave,
  input  logic [BIT_WIDTH-1:0] UpperLimit,
  input  logic [BIT_WIDTH-1:0] LowerLimit,
  input  logic [BIT_WIDTH-1:0] DutyCmd,
  input  logic                 DutyLoad,
  input  logic [DT_WIDTH-1:0]  DeadTime,
  input  logic                 FaultIn,
  input  logic                 FaultClr,
  output logic                 PwmHi,
  output logic                 PwmLo,
  output logic [BIT_WIDTH-1:0] DutyActive,
  output logic                 Fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO_ON = 3'd1,
    DT_HI = 3'd2,
    HI_ON = 3'd3,
    DT_LO = 3'd4
  } stateT;

  stateT                state;
  logic [DT_WIDTH-1:0]  cnt;
  logic [BIT_WIDTH-1:0] tWavePrev;
  logic                 dir;
  logic [BIT_WIDTH-1:0] shadow;
  logic                 pending;

  logic rising;
  logic falling;
  logic valley;
  logic transfer;
  logic raw;
  logic forceIdle;

  assign rising   = (TWave > tWavePrev);
  assign falling  = (TWave < tWavePrev);
  // Valley: carrier was heading down and has just turned upward.
  assign valley   = ~dir & rising;
  // Shadow reaches the compare register at a valley, or freely while idle.
  assign transfer = (state == IDLE) | (valley & pending);
  // Limits pin the extremes so 0 % / 100 % hold even if the carrier overshoots.
  assign raw      = (DutyActive > UpperLimit) ? 1'b1 :
                    (DutyActive <= LowerLimit) ? 1'b0 :
                    (TWave < DutyActive);
  // A fault arriving this cycle shuts the gates at the same edge it latches.
  assign forceIdle = ~En | Fault | FaultIn;

  // Track previous carrier sample and slope direction.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      tWavePrev <= '0;
      dir       <= 1'b0;
    end else begin
      tWavePrev <= TWave;
      if (rising) begin
        dir <= 1'b1;
      end else if (falling) begin
        dir <= 1'b0;
      end
    end
  end

  // Shadow register capture; a same-cycle load keeps Pending set for the new value.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (DutyLoad) begin
      shadow  <= DutyCmd;
      pending <= 1'b1;
    end else if (transfer) begin
      pending <= 1'b0;
    end
  end

  // Active compare value, updated from the shadow register.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      DutyActive <= '0;
    end else if (transfer) begin
      DutyActive <= shadow;
    end
  end

  // Fault latch: set dominates a simultaneous clear.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      Fault <= 1'b0;
    end else if (FaultIn) begin
      Fault <= 1'b1;
    end else if (FaultClr) begin
      Fault <= 1'b0;
    end
  end

  // Gate sequencer with dead-time counter; gates registered with the state.
  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      PwmHi <= 1'b0;
      PwmLo <= 1'b0;
    end else begin
      PwmHi <= 1'b0;
      PwmLo <= 1'b0;
      if (forceIdle) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state <= DT_LO;
            cnt   <= DeadTime;
          end
          LO_ON: begin
            if (raw) begin
              state <= DT_HI;
              cnt   <= DeadTime;
            end else begin
              PwmLo <= 1'b1;
            end
          end
          DT_HI: begin
            if (!raw) begin
              state <= LO_ON;
              PwmLo <= 1'b1;
            end else if (cnt == '0) begin
              state <= HI_ON;
              PwmHi <= 1'b1;
            end else begin
              cnt <= cnt - DT_WIDTH'(1);
            end
          end
          HI_ON: begin
            if (!raw) begin
              state <= DT_LO;
              cnt   <= DeadTime;
            end else begin
              PwmHi <= 1'b1;
            end
          end
          DT_LO: begin
            if (cnt == '0) begin
              if (raw) begin
                state <= DT_HI;
                cnt   <= DeadTime;
              end else begin
                state <= LO_ON;
                PwmLo <= 1'b1;
              end
            end else begin
              cnt <= cnt - DT_WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
